// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizes for the mux scan sequencer
package mux_scan_pkg;
  localparam int NCH = 8;
  localparam int ADDR_W = 3;
  localparam int SETTLE_W = 4;
  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;
endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: finds the lowest set mask bit, optionally restricted to indices above from
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]    mask,
  input  logic [ADDR_W-1:0] from,
  input  logic              above,
  output logic              found,
  output logic [ADDR_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i] && (!above || ADDR_W'(i) > from)) begin
        found = 1'b1;
        idx = ADDR_W'(i);
      end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: 8:1 mux channel sweeper with settle delay and valid/ready output
// Define MUX_SCAN_CONT_EN for continuous re-sweeping with mask resampled at each sweep end.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [WIDTH-1:0]  mux_data,
  output logic [ADDR_W-1:0] addr,
  output logic              nCS,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_t state, state_next;
  logic [SETTLE_W-1:0] cnt;
  logic [NCH-1:0] mask_q;
  logic lo_found, nx_found, hs, go, adv, wrap;
  logic [ADDR_W-1:0] lo_idx, nx_idx;
  mux_scan_next u_lo (.mask(chan_mask), .from('0), .above(1'b0), .found(lo_found), .idx(lo_idx));
  mux_scan_next u_nx (.mask(mask_q), .from(addr), .above(1'b1), .found(nx_found), .idx(nx_idx));
  assign hs = state == HOLD && out_valid && out_ready;
  assign go = state == IDLE && start && lo_found;
  assign adv = hs && nx_found;
`ifdef MUX_SCAN_CONT_EN
  assign wrap = hs && !nx_found && lo_found;
`else
  assign wrap = 1'b0;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_next = (go || adv || wrap) ? SELECT :
                 (state == SELECT && cnt == '0) ? HOLD :
                 hs ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      nCS <= 1'b1;
      out_data <= '0;
      out_chan <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      mask_q <= '0;
    end else begin
      done <= (state == IDLE && start && !lo_found) || (hs && !nx_found);
      if (go || wrap) mask_q <= chan_mask;
      if (hs) out_valid <= 1'b0;
      if (go || adv || wrap) begin
        addr <= adv ? nx_idx : lo_idx;
        nCS <= 1'b0;
        cnt <= SETTLE_W'(SETTLE);
      end else if (state == SELECT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          out_data <= mux_data;
          out_chan <= addr;
          out_valid <= 1'b1;
          nCS <= 1'b1;
        end
      end
    end
  end
endmodule
